// File: rtl/m_dram_arbiter.sv
// m_dram_arbiter: shares one fixed-latency, single-outstanding DRAM between
// the fetch port (0, read only) and the data port (1, read/write).
//
// Ports:
//   w_clock, w_reset            clock, synchronous active-high reset
//   w_req0, w_addr0             fetch read request, held until r_ack0
//   w_req1, w_we1, w_addr1,
//   w_wdata1                    data request, held until r_ack1
//   r_ack0, r_ack1              one-cycle completion pulses
//   r_rdata, r_err              read data / timeout flag, valid with ack
//   r_mem_re, r_mem_we          one-cycle DRAM strobes
//   r_mem_addr, r_mem_wdata     DRAM address / write data, held during access
//   w_mem_rdata, w_mem_oe       DRAM read data and completion strobe
//
// Parameter TIMEOUT (2..65535): cycles allowed in WAIT before abort.
// Macro ARB_RR_EN: round-robin on ties (default: port 1 beats port 0).

module m_dram_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        w_clock,
    input  logic        w_reset,
    input  logic        w_req0,
    input  logic [31:0] w_addr0,
    input  logic        w_req1,
    input  logic        w_we1,
    input  logic [31:0] w_addr1,
    input  logic [31:0] w_wdata1,
    output logic        r_ack0,
    output logic        r_ack1,
    output logic [31:0] r_rdata,
    output logic        r_err,
    output logic        r_mem_re,
    output logic        r_mem_we,
    output logic [31:0] r_mem_addr,
    output logic [31:0] r_mem_wdata,
    input  logic [31:0] w_mem_rdata,
    input  logic        w_mem_oe
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Watchdog fires when the count of WAIT cycles (this one included)
    // reaches TIMEOUT-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        gnt1_q;
    logic        we_q;
    logic        gnt1_d;

`ifdef ARB_RR_EN
    // Last granted port: 1 = port 1, 0 = port 0.
    logic        r_last;
`endif

    assign cnt_d = cnt_q + 16'd1;

    // Grant decision, only consumed in IDLE.
    always_comb begin
        gnt1_d = 1'b0;
`ifdef ARB_RR_EN
        if (w_req0 && w_req1) begin
            gnt1_d = ~r_last;
        end else begin
            gnt1_d = w_req1;
        end
`else
        gnt1_d = w_req1;
`endif
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            gnt1_q      <= 1'b0;
            we_q        <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
`ifdef ARB_RR_EN
            r_last      <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        gnt1_q      <= gnt1_d;
                        we_q        <= gnt1_d & w_we1;
                        r_mem_addr  <= gnt1_d ? w_addr1 : w_addr0;
                        r_mem_wdata <= gnt1_d ? w_wdata1 : 32'd0;
                        // Strobe registered here so it is high during ISSUE.
                        r_mem_re    <= ~(gnt1_d & w_we1);
                        r_mem_we    <= gnt1_d & w_we1;
`ifdef ARB_RR_EN
                        r_last      <= gnt1_d;
`endif
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_re <= 1'b0;
                    r_mem_we <= 1'b0;
                    cnt_q    <= 16'd0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // Completion wins over a coincident timeout.
                    if (w_mem_oe) begin
                        r_rdata <= we_q ? 32'd0 : w_mem_rdata;
                        r_err   <= 1'b0;
                        r_ack0  <= ~gnt1_q;
                        r_ack1  <= gnt1_q;
                        state_q <= S_RESP;
                    end else if (cnt_d == TO_LAST) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_ack0  <= ~gnt1_q;
                        r_ack1  <= gnt1_q;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ack0      <= 1'b0;
                    r_ack1      <= 1'b0;
                    r_err       <= 1'b0;
                    r_rdata     <= 32'd0;
                    r_mem_addr  <= 32'd0;
                    r_mem_wdata <= 32'd0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Directed bench for m_dram_arbiter with a fixed-latency DRAM model.
// Builds with or without ARB_RR_EN.

module tb_m_dram_arbiter;

    logic        clk;
    logic        w_reset;
    logic        w_req0;
    logic [31:0] w_addr0;
    logic        w_req1;
    logic        w_we1;
    logic [31:0] w_addr1;
    logic [31:0] w_wdata1;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_mem_rdata;
    logic        w_mem_oe;

    logic        m_oe;
    logic        stray_oe;
    logic        mem_en;
    logic [31:0] mdata;
    int          cyc;
    int          due;
    logic        pend;

    int vec;
    int miss;

    m_dram_arbiter #(.TIMEOUT(16)) dut (
        .w_clock     (clk),
        .w_reset     (w_reset),
        .w_req0      (w_req0),
        .w_addr0     (w_addr0),
        .w_req1      (w_req1),
        .w_we1       (w_we1),
        .w_addr1     (w_addr1),
        .w_wdata1    (w_wdata1),
        .r_ack0      (r_ack0),
        .r_ack1      (r_ack1),
        .r_rdata     (r_rdata),
        .r_err       (r_err),
        .r_mem_re    (r_mem_re),
        .r_mem_we    (r_mem_we),
        .r_mem_addr  (r_mem_addr),
        .r_mem_wdata (r_mem_wdata),
        .w_mem_rdata (w_mem_rdata),
        .w_mem_oe    (w_mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // DRAM model: a strobe seen in cycle s raises oe during cycle s+11,
    // so it is sampled at the edge ending that cycle.
    always @(negedge clk) begin
        m_oe = 1'b0;
        if (pend && cyc == due) begin
            m_oe = mem_en;
            pend = 1'b0;
        end
        if (r_mem_re || r_mem_we) begin
            pend = 1'b1;
            due  = cyc + 11;
        end
    end

    assign w_mem_oe    = m_oe | stray_oe;
    assign w_mem_rdata = mdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ticks_noack(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            if (r_ack0 || r_ack1) hits++;
            tick();
        end
    endtask

    // Port 0 read from IDLE; ack expected 13 cycles after the request.
    task automatic solo(input string tag, input logic [31:0] addr,
                        input logic [31:0] data);
        int h;
        mdata   = data;
        w_req0  = 1'b1;
        w_addr0 = addr;
        tick();
        chk({tag, "_re"}, 32'(r_mem_re), 32'd1);
        chk({tag, "_addr"}, r_mem_addr, addr);
        ticks_noack(12, h);
        chk({tag, "_early_ack"}, 32'(h), 32'd0);
        chk({tag, "_ack"}, 32'({r_ack1, r_ack0, r_err}), 32'b010);
        chk({tag, "_rdata"}, r_rdata, data);
        w_req0 = 1'b0;
        tick();
    endtask

    // Both ports request in the same cycle; first1 = port 1 expected first.
    task automatic tie(input string tag, input logic first1);
        int h;
        mdata   = 32'hCAFE0001;
        w_req0  = 1'b1;
        w_addr0 = 32'h40;
        w_req1  = 1'b1;
        w_we1   = 1'b0;
        w_addr1 = 32'h100;
        tick();
        chk({tag, "_1st_addr"}, r_mem_addr, first1 ? 32'h100 : 32'h40);
        ticks_noack(12, h);
        chk({tag, "_1st_early"}, 32'(h), 32'd0);
        chk({tag, "_1st_ack"}, 32'({r_ack1, r_ack0}),
            32'(first1 ? 2'b10 : 2'b01));
        chk({tag, "_1st_rdata"}, r_rdata, 32'hCAFE0001);
        if (first1) w_req1 = 1'b0;
        else        w_req0 = 1'b0;
        tick();
        chk({tag, "_gap"}, 32'(r_mem_re), 32'd0);
        tick();
        chk({tag, "_2nd_re"}, 32'(r_mem_re), 32'd1);
        chk({tag, "_2nd_addr"}, r_mem_addr, first1 ? 32'h40 : 32'h100);
        ticks_noack(12, h);
        chk({tag, "_2nd_early"}, 32'(h), 32'd0);
        chk({tag, "_2nd_ack"}, 32'({r_ack1, r_ack0}),
            32'(first1 ? 2'b01 : 2'b10));
        w_req0 = 1'b0;
        w_req1 = 1'b0;
        tick();
    endtask

    initial begin
        int   h;
        logic rr_first1;
        vec      = 0;
        miss     = 0;
        cyc      = 0;
        due      = 0;
        pend     = 1'b0;
        m_oe     = 1'b0;
        stray_oe = 1'b0;
        mem_en   = 1'b1;
        mdata    = 32'd0;
        w_reset  = 1'b1;
        w_req0   = 1'b0;
        w_addr0  = 32'd0;
        w_req1   = 1'b0;
        w_we1    = 1'b0;
        w_addr1  = 32'd0;
        w_wdata1 = 32'd0;
`ifdef ARB_RR_EN
        rr_first1 = 1'b0;
`else
        rr_first1 = 1'b1;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_ctl", 32'({r_ack0, r_ack1, r_err, r_mem_re, r_mem_we}), 32'd0);
        chk("rst_rdata", r_rdata, 32'd0);
        chk("rst_addr", r_mem_addr, 32'd0);
        chk("rst_wdata", r_mem_wdata, 32'd0);
        w_reset = 1'b0;
        tick();

        // Port 0 read: strobe next cycle, ack 13 cycles after request
        mdata   = 32'h00000013;
        w_req0  = 1'b1;
        w_addr0 = 32'h40;
        tick();
        chk("t1_re", 32'(r_mem_re), 32'd1);
        chk("t1_we", 32'(r_mem_we), 32'd0);
        chk("t1_addr", r_mem_addr, 32'h40);
        tick();
        chk("t1_re_pulse", 32'(r_mem_re), 32'd0);
        ticks_noack(11, h);
        chk("t1_early_ack", 32'(h), 32'd0);
        chk("t1_ack", 32'({r_ack1, r_ack0, r_err}), 32'b010);
        chk("t1_rdata", r_rdata, 32'h13);
        w_req0 = 1'b0;
        tick();
        chk("t1_ack_clr", 32'({r_ack0, r_err}), 32'd0);
        chk("t1_rdata_clr", r_rdata, 32'd0);

        // Port 1 write, with request fields changed mid-access
        mdata    = 32'h12345678;
        w_req1   = 1'b1;
        w_we1    = 1'b1;
        w_addr1  = 32'h80;
        w_wdata1 = 32'hDEADBEEF;
        tick();
        chk("t2_strobes", 32'({r_mem_we, r_mem_re}), 32'b10);
        chk("t2_addr", r_mem_addr, 32'h80);
        chk("t2_wdata", r_mem_wdata, 32'hDEADBEEF);
        w_addr1  = 32'h84;
        w_wdata1 = 32'h0;
        tick();
        chk("t2_we_pulse", 32'(r_mem_we), 32'd0);
        ticks_noack(10, h);
        chk("t2_wdata_held", r_mem_wdata, 32'hDEADBEEF);
        chk("t2_addr_held", r_mem_addr, 32'h80);
        if (r_ack0 || r_ack1) h++;
        tick();
        chk("t2_early_ack", 32'(h), 32'd0);
        chk("t2_ack", 32'({r_ack1, r_ack0, r_err}), 32'b100);
        chk("t2_rdata", r_rdata, 32'd0);
        w_req1 = 1'b0;
        w_we1  = 1'b0;
        tick();
        chk("t2_ack_clr", 32'(r_ack1), 32'd0);

        // Simultaneous requests after reset
        w_reset = 1'b1;
        tick();
        w_reset = 1'b0;
        tick();
        tie("t3a", rr_first1);
        solo("t3_solo", 32'h48, 32'h00000093);
        tie("t3b", 1'b1);

        // Watchdog abort, then a stray late oe
        mem_en  = 1'b0;
        w_req0  = 1'b1;
        w_addr0 = 32'h300;
        tick();
        chk("t4_re", 32'(r_mem_re), 32'd1);
        ticks_noack(16, h);
        chk("t4_early_ack", 32'(h), 32'd0);
        chk("t4_ack", 32'({r_ack1, r_ack0, r_err}), 32'b011);
        chk("t4_rdata", r_rdata, 32'd0);
        w_req0 = 1'b0;
        tick();
        chk("t4_ack_clr", 32'({r_ack0, r_err}), 32'd0);
        repeat (3) tick();
        stray_oe = 1'b1;
        tick();
        stray_oe = 1'b0;
        ticks_noack(4, h);
        chk("t4_stray_ack", 32'(h), 32'd0);
        chk("t4_stray_idle", 32'({r_mem_re, r_mem_we, r_err}), 32'd0);
        mem_en = 1'b1;

        // Reset during the fourth WAIT cycle of a port 1 read
        mdata   = 32'h55AA55AA;
        w_req1  = 1'b1;
        w_we1   = 1'b0;
        w_addr1 = 32'h200;
        tick();
        chk("t5_re", 32'(r_mem_re), 32'd1);
        repeat (4) tick();
        w_reset = 1'b1;
        w_req1  = 1'b0;
        tick();
        chk("t5_rst_ctl", 32'({r_ack0, r_ack1, r_err, r_mem_re, r_mem_we}),
            32'd0);
        chk("t5_rst_addr", r_mem_addr, 32'd0);
        chk("t5_rst_rdata", r_rdata, 32'd0);
        w_reset = 1'b0;
        ticks_noack(9, h);
        chk("t5_late_oe", 32'(h), 32'd0);
        chk("t5_idle", 32'(r_mem_re), 32'd0);
        solo("t5_req0", 32'h44, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
